// File: rtl/seg8_scan_if.sv
// Bundle between the 8-digit scan block and its display-data source / 74HC595 shifter.
interface seg8_scan_if;
  logic [31:0] Disp_Data;
  logic [7:0]  Dp;
  logic [7:0]  Disp_En;
  logic        Blank_Lead;
  logic [15:0] Data;
  logic        S_EN;

  modport master (input Disp_Data, Dp, Disp_En, Blank_Lead, output Data, S_EN);
  modport slave  (output Disp_Data, Dp, Disp_En, Blank_Lead, input Data, S_EN);
endinterface

// File: rtl/seg8_scan.sv
// Time-multiplexed 8-digit hex display scanner: one {SEL, SEG} word per slot,
// strobed out to a 595 shift stage, with per-frame input snapshot.
module seg8_scan #(
  parameter int SCAN_CNT_MAX = 50000
) (
  input logic        Clk,
  input logic        Reset_n,
  seg8_scan_if.master bus
);

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        blank_lead;
  } frame_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_CNT_MAX - 1);

  frame_t      live, snap, cur;
  logic        run, tick, s_en, blank;
  logic [15:0] div, data, word;
  logic [2:0]  idx;
  logic [7:0]  hi_zero;
  logic [3:0]  nib;
  logic [7:0]  seg;

  assign live = {bus.Disp_Data, bus.Dp, bus.Disp_En, bus.Blank_Lead};
  // Digit 0 is built from the values being captured on this very tick.
  assign cur  = (idx == 3'd0) ? live : snap;
  assign tick = run && (div == DIV_LAST);

  // hi_zero[i]: nibbles i..7 of the frame are all zero.
  for (genvar i = 0; i < 8; i++) begin : g_hz
    assign hi_zero[i] = (cur.digits[31:4*i] == '0);
  end

  always_comb begin
    nib = cur.digits[{idx, 2'b00} +: 4];
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    seg[7] = ~cur.dp[idx];
    blank  = !cur.en[idx] || (cur.blank_lead && (idx != 3'd0) && hi_zero[idx]);
    word   = blank ? 16'h00FF : {8'd1 << idx, seg};
  end

  // run gives the first post-reset edge to start-up, so the first strobe
  // lands SCAN_CNT_MAX+1 edges after release and later ones every SCAN_CNT_MAX.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run  <= 1'b0;
      div  <= '0;
      idx  <= '0;
      s_en <= 1'b0;
      data <= 16'h00FF;
      snap <= '0;
    end else begin
      run  <= 1'b1;
      s_en <= tick;
      if (run) div <= tick ? '0 : div + 16'd1;
      if (tick) begin
        data <= word;
        idx  <= idx + 3'd1;
        if (idx == 3'd0) snap <= live;
      end
    end
  end

  assign bus.Data = data;
  assign bus.S_EN = s_en;

endmodule

// File: tb/tb_seg8_scan.sv
// Randomized + directed bench for seg8_scan against a digit-rule reference model.
module tb_seg8_scan;
  localparam int MAX = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  seg8_scan_if bus();
  seg8_scan #(.SCAN_CNT_MAX(MAX)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [15:0] exp_word(input logic [31:0] d, input logic [7:0] dp,
                                           input logic [7:0] en, input logic bl, input int i);
    logic [3:0] n;
    logic [7:0] s;
    n = 4'((d >> (4 * i)) & 32'hF);
    if (!en[i] || (bl && i > 0 && (d >> (4 * i)) == 32'd0)) return 16'h00FF;
    s = tbl[n];
    if (dp[i]) s[7] = 1'b0;
    return {8'(1 << i), s};
  endfunction

  task automatic apply(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en, input logic bl);
    bus.Disp_Data = d; bus.Dp = dp; bus.Disp_En = en; bus.Blank_Lead = bl;
  endtask

  task automatic restart();
    @(posedge Clk); #1 Reset_n = 1'b0;
    @(posedge Clk); #1 Reset_n = 1'b1;
  endtask

  // Returns number of rising edges until S_EN is seen high (sampled 1 time unit after the edge).
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge Clk); #1; n++;
    end while (bus.S_EN !== 1'b1 && n < 40);
    if (bus.S_EN !== 1'b1) begin
      total++;
      $display("FAIL strobe_timeout: no S_EN after %0d edges", n);
    end
  endtask

  task automatic test_reset();
    apply(32'h0, 8'h0, 8'hFF, 1'b0);
    Reset_n = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      total++;
      if (bus.Data !== 16'h00FF) $display("FAIL reset_data: got %h want 00ff", bus.Data);
      else passed++;
      total++;
      if (bus.S_EN !== 1'b0) $display("FAIL reset_sen: got %b want 0", bus.S_EN);
      else passed++;
    end
  endtask

  task automatic test_sequence();
    logic [15:0] exp [8] = '{16'h01F8, 16'h0282, 16'h0492, 16'h0899,
                             16'h10B0, 16'h20A4, 16'h40F9, 16'h80C0};
    int n;
    apply(32'h01234567, 8'h00, 8'hFF, 1'b0);
    restart();
    for (int k = 0; k < 9; k++) begin
      wait_strobe(n);
      total++;
      if (n !== ((k == 0) ? MAX + 1 : MAX)) $display("FAIL seq_period[%0d]: got %0d want %0d", k, n, (k == 0) ? MAX + 1 : MAX);
      else passed++;
      total++;
      if (bus.Data !== exp[k % 8]) $display("FAIL seq_data[%0d]: got %h want %h", k, bus.Data, exp[k % 8]);
      else passed++;
    end
    // Between strobes S_EN is low and Data holds the last word.
    for (int c = 0; c < MAX - 1; c++) begin
      @(posedge Clk); #1;
      total++;
      if (bus.S_EN !== 1'b0 || bus.Data !== exp[0]) $display("FAIL hold[%0d]: got %b/%h want 0/%h", c, bus.S_EN, bus.Data, exp[0]);
      else passed++;
    end
  endtask

  task automatic test_frame(input string nm, input logic [31:0] d, input logic [7:0] dp,
                            input logic [7:0] en, input logic bl);
    int n;
    logic [15:0] e;
    apply(d, dp, en, bl);
    restart();
    for (int k = 0; k < 8; k++) begin
      wait_strobe(n);
      e = exp_word(d, dp, en, bl, k);
      total++;
      if (bus.Data !== e) $display("FAIL %s[%0d]: got %h want %h", nm, k, bus.Data, e);
      else passed++;
    end
  endtask

  task automatic test_dp_en();
    int n;
    apply(32'h01234567, 8'h04, 8'hFB, 1'b0);
    restart();
    wait_strobe(n);
    wait_strobe(n);
    total++;
    if (bus.Data !== 16'h0282) $display("FAIL dpen_d1: got %h want 0282", bus.Data);
    else passed++;
    wait_strobe(n);
    total++;
    if (bus.Data !== 16'h00FF) $display("FAIL dpen_d2: got %h want 00ff", bus.Data);
    else passed++;
  endtask

  task automatic test_tear();
    int n;
    logic [15:0] e;
    apply(32'h11111111, 8'h00, 8'hFF, 1'b0);
    restart();
    for (int k = 0; k < 16; k++) begin
      wait_strobe(n);
      e = {8'(1 << (k % 8)), (k < 8) ? 8'hF9 : 8'hA4};
      total++;
      if (bus.Data !== e) $display("FAIL tear[%0d]: got %h want %h", k, bus.Data, e);
      else passed++;
      if (k == 3) bus.Disp_Data = 32'h22222222;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    apply(32'h01234567, 8'h00, 8'hFF, 1'b0);
    restart();
    for (int k = 0; k < 6; k++) wait_strobe(n);
    Reset_n = 1'b0;
    #1;
    total++;
    if (bus.Data !== 16'h00FF || bus.S_EN !== 1'b0) $display("FAIL midreset_async: got %h/%b want 00ff/0", bus.Data, bus.S_EN);
    else passed++;
    @(posedge Clk); #1 Reset_n = 1'b1;
    wait_strobe(n);
    total++;
    if (n !== MAX + 1) $display("FAIL midreset_latency: got %0d want %0d", n, MAX + 1);
    else passed++;
    total++;
    if (bus.Data !== 16'h01F8) $display("FAIL midreset_d0: got %h want 01f8", bus.Data);
    else passed++;
  endtask

  task automatic test_random();
    int n;
    logic [31:0] d, sd;
    logic [7:0]  dp, en, sdp, sen;
    logic        bl, sbl;
    logic [15:0] e;
    d = 32'h0; dp = 8'h0; en = 8'hFF; bl = 1'b1;
    sd = d; sdp = dp; sen = en; sbl = bl;
    apply(d, dp, en, bl);
    restart();
    for (int k = 0; k < 96; k++) begin
      wait_strobe(n);
      if (k % 8 == 0) begin
        sd = d; sdp = dp; sen = en; sbl = bl;
      end
      e = exp_word(sd, sdp, sen, sbl, k % 8);
      total++;
      if (bus.Data !== e || n !== ((k == 0) ? MAX + 1 : MAX))
        $display("FAIL rand[%0d]: got %h after %0d edges want %h after %0d", k, bus.Data, n, e, (k == 0) ? MAX + 1 : MAX);
      else passed++;
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 8; j++) d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) d = d >> (4 * $urandom_range(1, 7));
        dp = 8'($urandom);
        en = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        bl = 1'($urandom);
        apply(d, dp, en, bl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_frame("blank_lead", 32'h00000120, 8'h00, 8'hFF, 1'b1);
    test_frame("no_blank", 32'h00000120, 8'h00, 8'hFF, 1'b0);
    test_frame("all_zero", 32'h00000000, 8'h00, 8'hFF, 1'b1);
    test_frame("dp_en", 32'h01234567, 8'h04, 8'hFB, 1'b0);
    test_dp_en();
    test_tear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg8_scan.md
SEG8_SCAN -- requirements
Module: seg8_scan

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: Clk, Reset_n.
REQ-002 The block SHALL have parameter SCAN_CNT_MAX, default 50000, Clk cycles per digit slot (1 ms at 50 MHz); legal range 2..65535.
REQ-003 Port Clk  input  1  system clock; all state on rising edge.
REQ-004 Port Reset_n  input  1  asynchronous active-low reset.
REQ-005 Port Disp_Data  input  32  eight hex digits; digit i = Disp_Data[4i+3:4i]; digit 0 is rightmost.
REQ-006 Port Dp  input  8  decimal point per digit; 1 = lit.
REQ-007 Port Disp_En  input  8  digit enable mask; 0 = digit dark.
REQ-008 Port Blank_Lead  input  1  1 = suppress leading zeros.
REQ-009 Port Data  output  16  word for the 74HC595 shift stage: Data[15:8] = digit select SEL (one-hot, 1 = digit on), Data[7:0] = segment code SEG (bit7 = dp, bits6:0 = g..a, active low).
REQ-010 Port S_EN  output  1  one-cycle load strobe; Data is valid whenever S_EN = 1.

Function
REQ-011 A divider SHALL count 0..SCAN_CNT_MAX-1 and wrap; tick = (divider == SCAN_CNT_MAX-1).
REQ-012 A 3-bit digit index idx SHALL advance on each tick, 0,1,...,7,0 with wrap-around.
REQ-013 On the clock edge ending a tick cycle, Data SHALL be loaded with the word for the current idx, and S_EN SHALL be 1 for exactly the following cycle; S_EN SHALL be 0 at all other times.
REQ-014 Data SHALL hold its value between strobes.
REQ-015 On a tick with idx = 0, Disp_Data, Dp, Disp_En and Blank_Lead SHALL be captured into a frame snapshot; digits 0..7 of that frame SHALL all be built from the snapshot, so input changes mid-frame never tear a frame.
REQ-016 Digit 0's word SHALL use the values being captured on that same tick.
REQ-017 Hex decode (SEG[6:0] with dp off, as 8-bit values), 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
REQ-018 SEG[7] SHALL be cleared to 0 when snapshot Dp[idx] = 1.
REQ-019 A digit SHALL be blank if any of the following holds: snapshot Disp_En[idx] = 0; or Blank_Lead = 1, idx > 0, and every nibble idx..7 of the snapshot is 0.
REQ-020 For a blank digit, Data SHALL be {8'h00, 8'hFF}; the Dp request SHALL be ignored.
REQ-021 For a non-blank digit, SEL SHALL be 8'b1 << idx.
REQ-022 Digit 0 SHALL never be blanked by Blank_Lead.
REQ-023 Integration constraint: SCAN_CNT_MAX SHALL be at least 33*(downstream shift divider) + 2, so each strobe arrives after the previous word has been latched; the block does not check this.

Reset
REQ-024 While Reset_n = 0, the following SHALL hold: divider = 0; idx = 0; S_EN = 0; Data = 16'h00FF (all digits off); snapshot = all zeros with Disp_En = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately.
REQ-026 After Reset_n rises, the first S_EN SHALL occur SCAN_CNT_MAX+1 rising edges later and SHALL carry digit 0 of a fresh snapshot.
REQ-027 Reset SHALL require no Clk edge to take effect.

Verification (SCAN_CNT_MAX = 4)
REQ-028 Disp_Data = 32'h01234567, Dp = 0, Disp_En = FF, Blank_Lead = 0, released from reset -> S_EN every 4 cycles. Data sequence: 01F8, 0282, 0492, 0899, 10B0, 20A4, 40F9, 80C0, then repeats from 01F8.
REQ-029 Disp_Data = 32'h00000120, Blank_Lead = 1, Disp_En = FF -> Data sequence: 01C0, 02A4, 04F9, then five words of 00FF; with Blank_Lead = 0, digits 3..7 each show C0.
REQ-030 Disp_Data = 0, Blank_Lead = 1 -> digit 0 shows 01C0; digits 1..7 show 00FF.
REQ-031 Dp = 8'h04, Disp_En = 8'hFB on the value of REQ-028 -> digit 2 word = 00FF (disable overrides dp); digit 1 word = 0282.
REQ-032 Disp_Data changed from 32'h11111111 to 32'h22222222 between the digit-3 and digit-4 strobes -> digits 4..7 still show F9; the next frame shows A4 for all digits.
REQ-033 Reset_n pulsed low for 1 cycle right after the digit-5 strobe -> Data = 00FF and S_EN = 0 immediately; the next strobe, 5 edges after release, is digit 0.
